// File: rtl/game_sequencer.sv
// ---------------------------------------------------------------------------
// game_sequencer
//
// Top-level controller for the VGA dodge game. Owns the IDLE/PLAY/PAUSE/OVER
// state machine, derives the movement `frame` tick from vertical-sync falling
// edges at a level-dependent rate, keeps the BCD score and speed level, and
// issues the one-clock restart pulse used by the player and bullet movers.
//
// Parameters
//   BASE_PERIOD : vsync edges per frame tick at level 0 (>= 2)
//   SCORE_DIV   : frame ticks per score point (>= 1)
//   BLINK_DIV   : vsync edges per blink toggle while in OVER
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous, active-high reset
//   vs_n     in   internal vertical sync, active-low
//   start    in   debounced start button level
//   frz      in   freeze / pause level
//   collide  in   player-bullet collision level
//   state    out  0 IDLE, 1 PLAY, 2 PAUSE, 3 OVER
//   frame    out  one-clock movement tick
//   play_rst out  one-clock restart pulse for the movers
//   score    out  4-digit BCD score (saturates at 9999)
//   level    out  speed level, saturating at min(3, BASE_PERIOD-1)
//   over     out  high while in OVER
//   blink    out  display flash toggled while in OVER
//   hiscore  out  best BCD score
//
// Build option
//   GAME_SEQ_HISCORE_EN : when defined, `hiscore` captures the best score on
//                         each entry to OVER and survives restarts (cleared
//                         only by rst). When undefined, `hiscore` is 0.
// ---------------------------------------------------------------------------
module game_sequencer #(
    parameter int BASE_PERIOD = 4,
    parameter int SCORE_DIV   = 8,
    parameter int BLINK_DIV   = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vs_n,
    input  logic        start,
    input  logic        frz,
    input  logic        collide,
    output logic [1:0]  state,
    output logic        frame,
    output logic        play_rst,
    output logic [15:0] score,
    output logic [1:0]  level,
    output logic        over,
    output logic        blink,
    output logic [15:0] hiscore
);

    localparam int VB_W    = $clog2(BASE_PERIOD + 1);
    localparam int FR_W    = (SCORE_DIV > 1) ? $clog2(SCORE_DIV + 1) : 1;
    localparam int BL_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV + 1) : 1;
    localparam int LVL_MAX = (BASE_PERIOD - 1 < 3) ? BASE_PERIOD - 1 : 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    // -----------------------------------------------------------------------
    // Registers and their next-state values
    // -----------------------------------------------------------------------
    state_t            state_q, state_d;
    logic              vs_q, st_q;
    logic [VB_W-1:0]   vb_cnt, vb_d;
    logic [FR_W-1:0]   fr_cnt, fr_d;
    logic [BL_W-1:0]   bl_cnt, bl_d;
    logic [15:0]       score_q, score_d;
    logic [1:0]        level_q, level_d;
    logic              lvl_inc, lvl_inc_d;
    logic              frame_q, frame_d;
    logic              play_rst_q, play_rst_d;
    logic              blink_q, blink_d;
    logic              over_q, over_d;

    // Edge detectors on the raw inputs against their registered copies.
    logic vedge, sedge;
    assign vedge = vs_q & ~vs_n;
    assign sedge = ~st_q & start;

    // Frame period shrinks by one vsync edge per level, never below one.
    logic [VB_W-1:0] lvl_ext, period;
    logic            tick_due;
    assign lvl_ext  = VB_W'(level_q);
    assign period   = (lvl_ext >= VB_W'(BASE_PERIOD)) ? VB_W'(1)
                                                     : VB_W'(BASE_PERIOD) - lvl_ext;
    // ">=" rather than "==" so a count left above a freshly shortened period
    // still wraps instead of running round the whole counter.
    assign tick_due = vedge && (vb_cnt >= period - VB_W'(1));

    // Four-digit BCD increment, holding at 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Next-state and datapath logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned; otherwise synthesis infers a latch.
        state_d    = state_q;
        vb_d       = vb_cnt;
        fr_d       = fr_cnt;
        bl_d       = bl_cnt;
        score_d    = score_q;
        level_d    = level_q;
        lvl_inc_d  = 1'b0;
        frame_d    = 1'b0;
        play_rst_d = 1'b0;
        blink_d    = blink_q;

        // A units-digit wrap seen last clock raises the level now.
        if (lvl_inc && (level_q < 2'(LVL_MAX)))
            level_d = level_q + 2'd1;

        case (state_q)
            S_IDLE: begin
                score_d = '0;
                level_d = '0;
                vb_d    = '0;
                fr_d    = '0;
                bl_d    = '0;
                blink_d = 1'b0;
                if (sedge) begin
                    state_d    = S_PLAY;
                    play_rst_d = 1'b1;
                end
            end

            S_PLAY: begin
                if (collide) begin
                    // Collision wins over a due tick and any pending score step.
                    state_d = S_OVER;
                end else begin
                    // Score follows the frame issued on the previous clock.
                    if (frame_q) begin
                        if (fr_cnt == FR_W'(SCORE_DIV - 1)) begin
                            fr_d      = '0;
                            score_d   = bcd_inc(score_q);
                            lvl_inc_d = (score_q != 16'h9999) && (score_q[3:0] == 4'd9);
                        end else begin
                            fr_d = fr_cnt + FR_W'(1);
                        end
                    end

                    if (frz) begin
                        // A vsync edge on the way into PAUSE is dropped.
                        state_d = S_PAUSE;
                    end else if (vedge) begin
                        if (tick_due) begin
                            vb_d    = '0;
                            frame_d = 1'b1;
                        end else begin
                            vb_d = vb_cnt + VB_W'(1);
                        end
                    end
                end
            end

            S_PAUSE: begin
                if (!frz)
                    state_d = S_PLAY;
            end

            S_OVER: begin
                if (sedge) begin
                    state_d    = S_PLAY;
                    play_rst_d = 1'b1;
                    score_d    = '0;
                    level_d    = '0;
                    vb_d       = '0;
                    fr_d       = '0;
                    bl_d       = '0;
                    blink_d    = 1'b0;
                end else if (vedge) begin
                    if (bl_cnt == BL_W'(BLINK_DIV - 1)) begin
                        bl_d    = '0;
                        blink_d = ~blink_q;
                    end else begin
                        bl_d = bl_cnt + BL_W'(1);
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        over_d = (state_d == S_OVER);
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            vs_q       <= 1'b0;
            st_q       <= 1'b0;
            vb_cnt     <= '0;
            fr_cnt     <= '0;
            bl_cnt     <= '0;
            score_q    <= '0;
            level_q    <= '0;
            lvl_inc    <= 1'b0;
            frame_q    <= 1'b0;
            play_rst_q <= 1'b0;
            blink_q    <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            vs_q       <= vs_n;
            st_q       <= start;
            vb_cnt     <= vb_d;
            fr_cnt     <= fr_d;
            bl_cnt     <= bl_d;
            score_q    <= score_d;
            level_q    <= level_d;
            lvl_inc    <= lvl_inc_d;
            frame_q    <= frame_d;
            play_rst_q <= play_rst_d;
            blink_q    <= blink_d;
            over_q     <= over_d;
        end
    end

    // -----------------------------------------------------------------------
    // Best score
    // -----------------------------------------------------------------------
`ifdef GAME_SEQ_HISCORE_EN
    logic [15:0] hiscore_q;

    // Packed BCD orders the same as binary, so a plain compare suffices.
    always_ff @(posedge clk) begin
        if (rst)
            hiscore_q <= '0;
        else if ((state_q == S_PLAY) && (state_d == S_OVER) && (score_q > hiscore_q))
            hiscore_q <= score_q;
    end

    assign hiscore = hiscore_q;
`else
    assign hiscore = 16'h0000;
`endif

    assign state    = state_q;
    assign frame    = frame_q;
    assign play_rst = play_rst_q;
    assign score    = score_q;
    assign level    = level_q;
    assign over     = over_q;
    assign blink    = blink_q;

endmodule
